counter_display_driver: RTL
===========================

Name: counter_display_driver

Overview:
- Downstream stage of the 5-bit counter: consumes its o_data bus and drives a 2-digit multiplexed common-anode 7-segment display.
- Converts binary 0..31 to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the two digits and blanks the leading zero.
- All outputs are registered.

Parameters:
- SCAN_DIV, 50000: clocks per digit scan slot; legal range ≥2.
- SEG_ACTIVE_LOW, 1: 1 drives segments low-true, 0 drives them high-true.
- AN_ACTIVE_LOW, 1: 1 drives anodes low-true, 0 drives them high-true.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous reset, active-high.
- i_data  input  5  binary value from the counter stage, range 0..31.
- i_blank  input  1  1 turns all segments and anodes off; internal state keeps running.
- o_seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}.
- o_an  output  2  digit enables; bit0 = ones digit, bit1 = tens digit.
- o_busy  output  1  1 while a conversion is in progress.

Behaviour:
- Reset (async, active-high) clears all state immediately:
  - FSM = IDLE; r_sample = 0; r_shown = 0; tens = 0; ones = 0.
  - Prescaler = 0; digit select = ones; o_busy = 0.
  - o_seg = all segments off (7'h7F when active-low); o_an = both digits off (2'b11 when active-low).
- Reset mid-conversion aborts the conversion; nothing is kept.
- Capture: r_sample <= i_data on every edge.
- FSM IDLE -> CONV:
  - Taken when r_sample != r_shown.
  - Loads shift register {8'b0, r_sample}; sets bit counter = 5; r_shown <= r_sample; o_busy <= 1.
- FSM CONV:
  - Each cycle: add 3 to any BCD nibble ≥5, then shift left by 1; decrement the counter.
  - Exit to DONE after 5 shifts.
- FSM DONE: writes tens/ones display registers; o_busy <= 0; returns to IDLE.
- Latency: value captured at edge k -> digit registers updated at edge k+7 -> seen on o_seg in the next cycle whose slot shows that digit.
- i_data changes while CONV/DONE are not queued:
  - Last-value-wins.
  - IDLE compares again at the next opportunity; intermediate values may be skipped.
- Width rule: the 8-bit BCD field holds tens 0..3 and ones 0..9; the input is never saturated.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - At terminal count: wraps to 0 and toggles digit select.
  - Outputs are registered, one clock behind select.
- Tens slot with tens == 0: segments off and tens anode off (leading-zero blank).
- Ones digit is always shown, so value 0 displays "0".
- Segment codes, active-high abcdefg sense: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Output is inverted when SEG_ACTIVE_LOW = 1.
  - A nibble >9 is unreachable; if it occurs, segments are off.
- i_blank = 1:
  - o_seg and o_an go to the off state on the next edge.
  - Conversion and prescaler continue; release resumes the current slot.

Decomposition:
- Package counter_display_pkg holds:
  - FSM enum: IDLE, CONV, DONE.
  - SEG_LUT constant array for 0..9.
  - SEG_OFF and AN_OFF constants.
  - BCD width constant.
- Sub-module bin2bcd_seq holds the FSM and shift register, with a start/busy/done interface and tens/ones outputs.
- Scan, blanking and encoding stay in the top module.

Test Plan:
- Reset check: assert i_reset mid-cycle -> o_seg = 7'h7F and o_an = 2'b11 immediately. After release with i_data = 0 and SCAN_DIV = 4, ones slot shows o_an = 2'b10, o_seg = 7'b1000000, and the tens slot is fully off.
- i_data = 16 -> o_busy high for 6 cycles; digits update at edge k+7. Ones slot shows 2'b10 / 7'b0000010 ("6"); tens slot shows 2'b01 / 7'b1111001 ("1").
- i_data = 7 -> ones slot shows 7'b1111000; tens slot shows o_an = 2'b11 and o_seg = 7'h7F.
- i_data = 12 then 25 one cycle later -> 12 converts and displays, then 25 is converted. "2"/"5" are shown by edge k+15 and no stale value remains after that.
- Boundary i_data = 31 -> tens = 3 ("0110000"), ones = 1 ("1111001").
- i_reset pulse during CONV of 20 -> display returns to "0" and o_busy = 0 after release. i_blank pulse -> outputs off next edge; prescaler count is continuous across the pulse.

Source files
------------

// File: rtl/counter_display_driver_pkg.sv
// counter_display_pkg: shared types and constants for the 2-digit counter display
package counter_display_pkg;
    localparam int DATA_W = 5;
    localparam int BCD_W = 8;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;
    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [1:0] AN_OFF = 2'b00;
    localparam logic [6:0] SEG_LUT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        return d <= 4'd9 ? SEG_LUT[d] : SEG_OFF;
    endfunction
endpackage

// File: rtl/counter_display_driver_if.sv
// counter_display_driver_if: data/blank inputs and display drive outputs of the display stage
interface counter_display_driver_if;
    import counter_display_pkg::*;
    logic [DATA_W-1:0] i_data;
    logic              i_blank;
    logic [6:0]        o_seg;
    logic [1:0]        o_an;
    logic              o_busy;
    modport master (output i_data, i_blank, input o_seg, o_an, o_busy);
    modport slave (input i_data, i_blank, output o_seg, o_an, o_busy);
endinterface

// File: rtl/counter_display_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 5-bit binary to tens/ones BCD
module bin2bcd_seq
    import counter_display_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] bin_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [3:0]        tens_o,
    output logic [3:0]        ones_o
);
    state_e state_q;
    logic [BCD_W+DATA_W-1:0] sr_q;
    logic [2:0] cnt_q;
    logic [BCD_W-1:0] adj;
    always_comb begin
        adj[7:4] = sr_q[12:9] >= 4'd5 ? sr_q[12:9] + 4'd3 : sr_q[12:9];
        adj[3:0] = sr_q[8:5] >= 4'd5 ? sr_q[8:5] + 4'd3 : sr_q[8:5];
    end
    assign done_o = state_q == DONE;
    assign tens_o = sr_q[12:9];
    assign ones_o = sr_q[8:5];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    sr_q    <= {{BCD_W{1'b0}}, bin_i};
                    cnt_q   <= 3'd5;
                    busy_o  <= 1'b1;
                    state_q <= CONV;
                end
                CONV: begin
                    sr_q    <= {adj[6:0], sr_q[4:0], 1'b0};
                    cnt_q   <= cnt_q - 3'd1;
                    state_q <= cnt_q == 3'd1 ? DONE : CONV;
                end
                DONE: begin
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: rtl/counter_display_driver.sv
// counter_display_driver: converts the 5-bit count to BCD and scans it onto a
// 2-digit multiplexed 7-segment display with leading-zero blanking
module counter_display_driver
    import counter_display_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input logic i_clk,
    input logic i_reset,
    counter_display_driver_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0] AN_POL = {2{AN_ACTIVE_LOW}};
    logic [DATA_W-1:0] r_sample_q, r_shown_q;
    logic [3:0] tens_q, ones_q, tens, ones, digit;
    logic [PW-1:0] pre_q;
    logic [6:0] seg_q;
    logic [1:0] an_q;
    logic sel_q, start, busy, done, off, tc;
    assign start = !busy && r_sample_q != r_shown_q;
    assign tc = pre_q == PW'(SCAN_DIV - 1);
    assign digit = sel_q ? tens_q : ones_q;
    // tens slot with a zero tens digit is dark, so single-digit values show one digit
    assign off = bus.i_blank || (sel_q && tens_q == 4'd0);
    assign bus.o_seg = seg_q;
    assign bus.o_an = an_q;
    assign bus.o_busy = busy;
    bin2bcd_seq u_conv (
        .clk     (i_clk),
        .rst     (i_reset),
        .start_i (start),
        .bin_i   (r_sample_q),
        .busy_o  (busy),
        .done_o  (done),
        .tens_o  (tens),
        .ones_o  (ones)
    );
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sample_q <= '0;
            r_shown_q  <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            pre_q      <= '0;
            sel_q      <= 1'b0;
            seg_q      <= SEG_OFF ^ SEG_POL;
            an_q       <= AN_OFF ^ AN_POL;
        end else begin
            r_sample_q <= bus.i_data;
            if (start) r_shown_q <= r_sample_q;
            if (done) begin
                tens_q <= tens;
                ones_q <= ones;
            end
            pre_q <= tc ? '0 : pre_q + PW'(1);
            sel_q <= sel_q ^ tc;
            seg_q <= (off ? SEG_OFF : seg_code(digit)) ^ SEG_POL;
            an_q  <= (off ? AN_OFF : (sel_q ? 2'b10 : 2'b01)) ^ AN_POL;
        end
    end
endmodule
